// File: rtl/doorbell_sequencer.sv
// Push-button to two-tone chime controller: synchroniser, debouncer, DING/DONG/COOL
// sequencer driving the sound-mux select and output gate.
module doorbell_sequencer #(
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int DING_CYCLES     = 8,
  parameter int DONG_CYCLES     = 12,
  parameter int COOL_CYCLES     = 6
) (
  input  logic clk,
  input  logic rst,
  input  logic button,
  output logic sel,
  output logic chime_on,
  output logic busy,
  output logic done
);

  localparam int MAX_DD = (DING_CYCLES > DONG_CYCLES) ? DING_CYCLES : DONG_CYCLES;
  localparam int MAX_P  = (MAX_DD > COOL_CYCLES) ? MAX_DD : COOL_CYCLES;
  localparam int PW     = $clog2(MAX_P + 1);
  localparam int DW     = $clog2(DEBOUNCE_CYCLES + 1);

  localparam logic [PW-1:0] DING_LD = PW'(DING_CYCLES - 1);
  localparam logic [PW-1:0] DONG_LD = PW'(DONG_CYCLES - 1);
  localparam logic [PW-1:0] COOL_LD = PW'(COOL_CYCLES - 1);
  localparam logic [DW-1:0] DB_LAST = DW'(DEBOUNCE_CYCLES - 1);

  typedef enum logic [1:0] {IDLE, DING, DONG, COOL} state_t;

  state_t          state_q, state_d;
  logic [PW-1:0]   pcnt_q, pcnt_d;
  logic            s1_q, s2_q;
  logic [DW-1:0]   dcnt_q, dcnt_d;
  logic            db_q, db_d, db_prev_q;
  logic [1:0]      vld_q, vld_d;
  logic [DW-1:0]   lcnt_q, lcnt_d;
  logic            arm_q, arm_d;
  logic            sel_q, sel_d, chime_q, chime_d, busy_q, busy_d, done_q, done_d;
  logic            press;

  // A rising edge only counts once the button has been seen released after reset,
  // so a button held through reset cannot start a chime on its own.
  assign press = db_q & ~db_prev_q & arm_q;

  always_comb begin
    dcnt_d = '0;
    db_d   = db_q;
    if (s2_q != db_q) begin
      if (dcnt_q == DB_LAST) db_d = ~db_q;
      else                   dcnt_d = dcnt_q + DW'(1);
    end

    // vld_q masks the reset-value cycles of the synchroniser.
    vld_d  = {vld_q[0], 1'b1};
    lcnt_d = lcnt_q;
    arm_d  = arm_q;
    if (vld_q[1] && !arm_q) begin
      if (s2_q)                  lcnt_d = '0;
      else if (lcnt_q == DB_LAST) arm_d = 1'b1;
      else                       lcnt_d = lcnt_q + DW'(1);
    end
  end

  always_comb begin
    state_d = state_q;
    pcnt_d  = pcnt_q;
    case (state_q)
      IDLE: if (press) begin
        state_d = DING;
        pcnt_d  = DING_LD;
      end
      DING: if (pcnt_q == '0) begin
        state_d = DONG;
        pcnt_d  = DONG_LD;
      end else pcnt_d = pcnt_q - PW'(1);
      DONG: if (pcnt_q == '0) begin
        state_d = COOL;
        pcnt_d  = COOL_LD;
      end else pcnt_d = pcnt_q - PW'(1);
      COOL: if (pcnt_q == '0) state_d = IDLE;
            else              pcnt_d  = pcnt_q - PW'(1);
      default: begin
        state_d = IDLE;
        pcnt_d  = '0;
      end
    endcase

    sel_d   = (state_d == DONG);
    chime_d = (state_d == DING) || (state_d == DONG);
    busy_d  = (state_d != IDLE);
    done_d  = (state_q == COOL) && (state_d == IDLE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      pcnt_q    <= '0;
      s1_q      <= 1'b0;
      s2_q      <= 1'b0;
      dcnt_q    <= '0;
      db_q      <= 1'b0;
      db_prev_q <= 1'b0;
      vld_q     <= '0;
      lcnt_q    <= '0;
      arm_q     <= 1'b0;
      sel_q     <= 1'b0;
      chime_q   <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      pcnt_q    <= pcnt_d;
      s1_q      <= button;
      s2_q      <= s1_q;
      dcnt_q    <= dcnt_d;
      db_q      <= db_d;
      db_prev_q <= db_q;
      vld_q     <= vld_d;
      lcnt_q    <= lcnt_d;
      arm_q     <= arm_d;
      sel_q     <= sel_d;
      chime_q   <= chime_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
    end
  end

  assign sel      = sel_q;
  assign chime_on = chime_q;
  assign busy     = busy_q;
  assign done     = done_q;

endmodule

// File: tb/tb_doorbell_sequencer.sv
// Directed bench for doorbell_sequencer at default parameters.
module tb_doorbell_sequencer;

  logic clk = 1'b0;
  logic rst;
  logic button;
  logic sel, chime_on, busy, done;

  int checks = 0;
  int errors = 0;

  // Edge numbers relative to the first edge sampling the press (D=4, DING=8, DONG=12, COOL=6)
  localparam int T_ON   = 7;
  localparam int T_DONG = T_ON + 8;
  localparam int T_COOL = T_DONG + 12;
  localparam int T_DONE = T_COOL + 6;

  doorbell_sequencer dut (
    .clk      (clk),
    .rst      (rst),
    .button   (button),
    .sel      (sel),
    .chime_on (chime_on),
    .busy     (busy),
    .done     (done)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // {sel, chime_on, busy, done} expected just after edge k of a chime
  function automatic logic [3:0] exp_out(int k);
    logic [3:0] e;
    e[3] = (k >= T_DONG) && (k < T_COOL);
    e[2] = (k >= T_ON)   && (k < T_COOL);
    e[1] = (k >= T_ON)   && (k < T_DONE);
    e[0] = (k == T_DONE);
    return e;
  endfunction

  task automatic test_reset();
    rst = 1'b1;
    button = 1'b0;
    #1;
    checks++;
    if ({sel, chime_on, busy, done} !== 4'b0000) begin
      errors++;
      $display("FAIL reset_async got=%b exp=0000", {sel, chime_on, busy, done});
    end
    step(); step();
    rst = 1'b0;
    for (int i = 0; i < 20; i++) begin
      step();
      checks++;
      if ({sel, chime_on, busy, done} !== 4'b0000) begin
        errors++;
        $display("FAIL reset_idle cyc=%0d got=%b exp=0000", i, {sel, chime_on, busy, done});
      end
    end
  endtask

  task automatic test_single_chime();
    button = 1'b1;
    for (int k = 1; k <= 40; k++) begin
      step();
      checks++;
      if ({sel, chime_on, busy, done} !== exp_out(k)) begin
        errors++;
        $display("FAIL single_chime k=%0d got=%b exp=%b", k, {sel, chime_on, busy, done}, exp_out(k));
      end
    end
    button = 1'b0;
    for (int i = 0; i < 10; i++) step();
  endtask

  task automatic test_bounce();
    logic [19:0] pat;
    pat = 20'b00000000000011011100;  // LSB first: 0,0,1,1,1,0,1,1,0,...
    for (int i = 0; i < 20; i++) begin
      button = pat[i];
      step();
      checks++;
      if ({chime_on, busy} !== 2'b00) begin
        errors++;
        $display("FAIL bounce cyc=%0d got=%b exp=00", i, {chime_on, busy});
      end
    end
    for (int i = 0; i < 10; i++) step();
  endtask

  task automatic test_retrigger();
    button = 1'b1;
    for (int k = 1; k <= 40; k++) begin
      step();
      checks++;
      if ({sel, chime_on, busy, done} !== exp_out(k)) begin
        errors++;
        $display("FAIL retrigger k=%0d got=%b exp=%b", k, {sel, chime_on, busy, done}, exp_out(k));
      end
      // release in DING, press lands in DONG, second press lands on the COOL->IDLE edge
      case (k)
        9:  button = 1'b0;
        17: button = 1'b1;
        21: button = 1'b0;
        26: button = 1'b1;
        40: button = 1'b0;
        default: ;
      endcase
    end
    for (int i = 0; i < 10; i++) step();
    button = 1'b1;
    for (int k = 1; k <= 40; k++) begin
      step();
      checks++;
      if ({sel, chime_on, busy, done} !== exp_out(k)) begin
        errors++;
        $display("FAIL second_chime k=%0d got=%b exp=%b", k, {sel, chime_on, busy, done}, exp_out(k));
      end
    end
    button = 1'b0;
    for (int i = 0; i < 10; i++) step();
  endtask

  task automatic test_hold();
    button = 1'b1;
    for (int k = 1; k <= 60; k++) begin
      step();
      checks++;
      if ({sel, chime_on, busy, done} !== exp_out(k)) begin
        errors++;
        $display("FAIL hold k=%0d got=%b exp=%b", k, {sel, chime_on, busy, done}, exp_out(k));
      end
    end
    button = 1'b0;
    for (int i = 0; i < 10; i++) step();
  endtask

  task automatic test_reset_mid_dong();
    button = 1'b1;
    for (int k = 1; k <= 20; k++) step();
    checks++;
    if ({sel, chime_on, busy} !== 3'b111) begin
      errors++;
      $display("FAIL pre_reset_dong got=%b exp=111", {sel, chime_on, busy});
    end
    #2 rst = 1'b1;
    #1;
    checks++;
    if ({sel, chime_on, busy, done} !== 4'b0000) begin
      errors++;
      $display("FAIL reset_mid_dong got=%b exp=0000", {sel, chime_on, busy, done});
    end
    step(); step();
    rst = 1'b0;
    for (int i = 0; i < 30; i++) begin
      step();
      checks++;
      if ({sel, chime_on, busy, done} !== 4'b0000) begin
        errors++;
        $display("FAIL held_after_reset cyc=%0d got=%b exp=0000", i, {sel, chime_on, busy, done});
      end
    end
    button = 1'b0;
    for (int i = 0; i < 5; i++) step();
    button = 1'b1;
    for (int k = 1; k <= 40; k++) begin
      step();
      checks++;
      if ({sel, chime_on, busy, done} !== exp_out(k)) begin
        errors++;
        $display("FAIL rearm_chime k=%0d got=%b exp=%b", k, {sel, chime_on, busy, done}, exp_out(k));
      end
    end
    button = 1'b0;
    for (int i = 0; i < 10; i++) step();
  endtask

  initial begin
    test_reset();
    test_single_chime();
    test_bounce();
    test_retrigger();
    test_hold();
    test_reset_mid_dong();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
